// File: rtl/dual_port_read_memory_pkg.sv
// -----------------------------------------------------------------------------
// dual_port_read_memory_pkg
//
// Shared defaults and helpers for the dual-port-read memory slice.
//   - Default geometry: DATA_W_DEF x DEPTH_DEF words, ADDR_W_DEF address bits.
//   - DATA_RESET_BIT: the bit replicated across a data output on reset, so
//     every width of output register clears to the same all-zeros value.
//   - addrInRange(): address bounds check against the configured depth. It
//     only matters when DEPTH is smaller than 2**ADDR_W.
// -----------------------------------------------------------------------------
package dual_port_read_memory_pkg;

    localparam int DATA_W_DEF = 32'd8;
    localparam int ADDR_W_DEF = 32'd10;
    localparam int DEPTH_DEF  = 32'd1024;

    // Every data output clears to all zeros; replicated to the port width.
    localparam logic DATA_RESET_BIT = 1'b0;

    // True when the address selects a real word of the array.
    function automatic logic addrInRange(input int unsigned addr, input int unsigned depth);
        logic inRange;
        if (addr < depth) begin
            inRange = 1'b1;
        end else begin
            inRange = 1'b0;
        end
        return inRange;
    endfunction

endpackage

// File: rtl/dual_port_read_memory_ram_sdp_core.sv
// -----------------------------------------------------------------------------
// ram_sdp_core
//
// Simple dual-port storage: DEPTH x DATA_W array with one write port and one
// synchronous read port. The single read word is registered straight into two
// enable-gated holding registers (a and b), so each consumer sees its data one
// edge after its strobe and keeps it until its next strobe.
//
// Read-during-write to the same address is write-first: the incoming write
// data is forwarded to the read path in the same edge the array is updated.
//
// The core is deliberately policy-free: the caller decides which writes are
// legal (iWriteEnable already gated), which reads must return zero
// (iReadZero) and when the holding registers clear (iClear).
//
// Ports:
//   Clock          in   rising-edge clock
//   iClear         in   synchronous clear of both holding registers (wins)
//   iWriteEnable   in   qualified write strobe
//   iWriteAddress  in   ADDR_W write address (assumed in range when enabled)
//   iWriteData     in   DATA_W write data
//   iReadAddress   in   ADDR_W shared read address
//   iReadEnA       in   load holding register a
//   iReadEnB       in   load holding register b
//   iReadZero      in   load zero instead of the array word (address invalid)
//   oDataA         out  holding register a
//   oDataB         out  holding register b
// -----------------------------------------------------------------------------
module ram_sdp_core
    import dual_port_read_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              Clock,
    input  logic              iClear,
    input  logic              iWriteEnable,
    input  logic [ADDR_W-1:0] iWriteAddress,
    input  logic [DATA_W-1:0] iWriteData,
    input  logic [ADDR_W-1:0] iReadAddress,
    input  logic              iReadEnA,
    input  logic              iReadEnB,
    input  logic              iReadZero,
    output logic [DATA_W-1:0] oDataA,
    output logic [DATA_W-1:0] oDataB
);

    // Index width of the physical array; never below one bit.
    localparam int IDX_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{DATA_RESET_BIT}};

    // No reset on the array: contents survive Reset, which keeps it a plain
    // block RAM with no clear logic.
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [IDX_W-1:0]  writeIdx_s;
    logic [IDX_W-1:0]  readIdx_s;
    logic              bypass_s;
    logic [DATA_W-1:0] readWord_s;
    logic [DATA_W-1:0] dataA_r;
    logic [DATA_W-1:0] dataB_r;

    assign writeIdx_s = iWriteAddress[IDX_W-1:0];
    assign readIdx_s  = iReadAddress[IDX_W-1:0];

    // Array write port.
    always_ff @(posedge Clock) begin
        if (iWriteEnable) begin
            mem_r[writeIdx_s] <= iWriteData;
        end
    end

    // Read word selection: write-first forwarding on an address match,
    // zero for an invalid address, otherwise the stored word.
    always_comb begin
        bypass_s   = 1'b0;
        readWord_s = mem_r[readIdx_s];
        if (iWriteEnable && (iWriteAddress == iReadAddress)) begin
            bypass_s = 1'b1;
        end else begin
            bypass_s = 1'b0;
        end
        if (iReadZero) begin
            readWord_s = DATA_ZERO;
        end else if (bypass_s) begin
            readWord_s = iWriteData;
        end else begin
            readWord_s = mem_r[readIdx_s];
        end
    end

    // Holding register a: clears on iClear, loads on its strobe, else holds.
    always_ff @(posedge Clock) begin
        if (iClear) begin
            dataA_r <= DATA_ZERO;
        end else if (iReadEnA) begin
            dataA_r <= readWord_s;
        end else begin
            dataA_r <= dataA_r;
        end
    end

    // Holding register b: same policy as a, on its own strobe.
    always_ff @(posedge Clock) begin
        if (iClear) begin
            dataB_r <= DATA_ZERO;
        end else if (iReadEnB) begin
            dataB_r <= readWord_s;
        end else begin
            dataB_r <= dataB_r;
        end
    end

    assign oDataA = dataA_r;
    assign oDataB = dataB_r;

endmodule

// File: rtl/dual_port_read_memory.sv
// -----------------------------------------------------------------------------
// dual_port_read_memory
//
// 1024 x 8 synchronous RAM with one write port and two independently strobed
// registered read outputs sharing one read address. A producer writes by
// address; two consumers each pull a word on their own strobe.
//
// This level owns the access policy:
//   - Reset suppresses writes and reads and clears both outputs; the array
//     itself is never cleared.
//   - Writes to addresses >= DEPTH are dropped; strobed reads of such
//     addresses load zero.
// The array, write-first forwarding and the output registers live in
// ram_sdp_core, so the outputs are plain registers with no combinational
// path from any input.
//
// Ports:
//   Clock          in   rising-edge clock
//   Reset          in   synchronous, active-high
//   iWriteEnable   in   write strobe
//   iAddress       in   ADDR_W write address
//   iDataIn        in   DATA_W write data
//   iReadAddress   in   ADDR_W shared read address
//   iReadtoa       in   read strobe, output a
//   iReadtob       in   read strobe, output b
//   oDataOuta      out  registered read data, port a (1-cycle latency)
//   oDataOutb      out  registered read data, port b (1-cycle latency)
// -----------------------------------------------------------------------------
module dual_port_read_memory
    import dual_port_read_memory_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iWriteEnable,
    input  logic [ADDR_W-1:0] iAddress,
    input  logic [DATA_W-1:0] iDataIn,
    input  logic [ADDR_W-1:0] iReadAddress,
    input  logic              iReadtoa,
    input  logic              iReadtob,
    output logic [DATA_W-1:0] oDataOuta,
    output logic [DATA_W-1:0] oDataOutb
);

    logic writeInRange_s;
    logic readInRange_s;
    logic writeEn_s;
    logic readEnA_s;
    logic readEnB_s;
    logic readZero_s;

    assign writeInRange_s = addrInRange(32'(iAddress), 32'(DEPTH));
    assign readInRange_s  = addrInRange(32'(iReadAddress), 32'(DEPTH));

    // Access qualification: nothing reaches the array or the read strobes
    // while Reset is high, and out-of-range writes are dropped.
    always_comb begin
        writeEn_s  = 1'b0;
        readEnA_s  = 1'b0;
        readEnB_s  = 1'b0;
        readZero_s = 1'b0;
        if (Reset) begin
            writeEn_s = 1'b0;
            readEnA_s = 1'b0;
            readEnB_s = 1'b0;
        end else begin
            writeEn_s = iWriteEnable & writeInRange_s;
            readEnA_s = iReadtoa;
            readEnB_s = iReadtob;
        end
        if (readInRange_s) begin
            readZero_s = 1'b0;
        end else begin
            readZero_s = 1'b1;
        end
    end

    ram_sdp_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) uCore (
        .Clock         (Clock),
        .iClear        (Reset),
        .iWriteEnable  (writeEn_s),
        .iWriteAddress (iAddress),
        .iWriteData    (iDataIn),
        .iReadAddress  (iReadAddress),
        .iReadEnA      (readEnA_s),
        .iReadEnB      (readEnB_s),
        .iReadZero     (readZero_s),
        .oDataA        (oDataOuta),
        .oDataB        (oDataOutb)
    );

endmodule

// File: tb/tb_dual_port_read_memory.sv
// -----------------------------------------------------------------------------
// tb_dual_port_read_memory
//
// Directed scenarios followed by randomized traffic. A reference model (a
// plain array plus "written" flags) predicts each output after every edge;
// words never written since power-up are unknown and not compared.
// -----------------------------------------------------------------------------
module tb_dual_port_read_memory;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              Clock = 1'b0;
    logic              Reset;
    logic              iWriteEnable;
    logic [ADDR_W-1:0] iAddress;
    logic [DATA_W-1:0] iDataIn;
    logic [ADDR_W-1:0] iReadAddress;
    logic              iReadtoa;
    logic              iReadtob;
    logic [DATA_W-1:0] oDataOuta;
    logic [DATA_W-1:0] oDataOutb;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [DATA_W-1:0] refMem [DEPTH];
    bit                refKnown [DEPTH];
    logic [DATA_W-1:0] expA;
    logic [DATA_W-1:0] expB;
    bit                knownA = 1'b0;
    bit                knownB = 1'b0;

    dual_port_read_memory #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iWriteEnable (iWriteEnable),
        .iAddress     (iAddress),
        .iDataIn      (iDataIn),
        .iReadAddress (iReadAddress),
        .iReadtoa     (iReadtoa),
        .iReadtob     (iReadtob),
        .oDataOuta    (oDataOuta),
        .oDataOutb    (oDataOutb)
    );

    always #5 Clock = ~Clock;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit we, input int wa, input int wd,
                         input int ra, input bit a, input bit b);
        Reset        = rst;
        iWriteEnable = we;
        iAddress     = ADDR_W'(wa);
        iDataIn      = DATA_W'(wd);
        iReadAddress = ADDR_W'(ra);
        iReadtoa     = a;
        iReadtob     = b;
    endtask

    // One clock: apply the model to the inputs seen at the edge, then compare
    // every output whose expected value is known.
    task automatic cycle();
        logic [DATA_W-1:0] word;
        bit                wordKnown;
        int                ra;
        int                wa;
        @(posedge Clock);
        ra = int'(iReadAddress);
        wa = int'(iAddress);
        if (Reset) begin
            expA   = '0;
            expB   = '0;
            knownA = 1'b1;
            knownB = 1'b1;
        end else begin
            if (ra >= DEPTH) begin
                word      = '0;
                wordKnown = 1'b1;
            end else if (iWriteEnable && wa == ra) begin
                word      = iDataIn;
                wordKnown = 1'b1;
            end else begin
                word      = refMem[ra];
                wordKnown = refKnown[ra];
            end
            if (iReadtoa) begin
                expA   = word;
                knownA = wordKnown;
            end
            if (iReadtob) begin
                expB   = word;
                knownB = wordKnown;
            end
            if (iWriteEnable && wa < DEPTH) begin
                refMem[wa]   = iDataIn;
                refKnown[wa] = 1'b1;
            end
        end
        #1;
        if (knownA) checkVal("model_a", oDataOuta, expA);
        if (knownB) checkVal("model_b", oDataOutb, expB);
    endtask

    initial begin
        int k;
        int wa;
        for (int i = 0; i < DEPTH; i++) refKnown[i] = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        #2;

        // Reset held two cycles with both strobes high and a write to addr 5.
        drive(1'b1, 1'b1, 5, 8'hAA, 5, 1'b1, 1'b1);
        cycle();
        cycle();
        checkVal("rst_a", oDataOuta, 8'h00);
        checkVal("rst_b", oDataOutb, 8'h00);
        drive(1'b0, 1'b0, 0, 0, 5, 1'b1, 1'b0);
        cycle();
        checkVal("rst_nowrite", (oDataOuta == 8'hAA), 1'b0);

        // Fill every address with its low byte, then read all back on a.
        for (k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b1, k, k[7:0], 0, 1'b0, 1'b0);
            cycle();
        end
        for (k = 0; k < DEPTH; k++) begin
            drive(1'b0, 1'b0, 0, 0, k, 1'b1, 1'b0);
            cycle();
            checkVal("wr_rd_a", oDataOuta, k[7:0]);
            if (k % 256 == 255) checkVal("b_hold", oDataOutb, 8'h00);
        end

        // Independent ports.
        drive(1'b0, 1'b0, 0, 0, 10, 1'b1, 1'b0);
        cycle();
        checkVal("ind_a10", oDataOuta, 8'h0A);
        drive(1'b0, 1'b0, 0, 0, 20, 1'b0, 1'b1);
        cycle();
        checkVal("ind_a_hold", oDataOuta, 8'h0A);
        checkVal("ind_b20", oDataOutb, 8'h14);
        drive(1'b0, 1'b0, 0, 0, 3, 1'b1, 1'b1);
        cycle();
        checkVal("both_a3", oDataOuta, 8'h03);
        checkVal("both_b3", oDataOutb, 8'h03);

        // Write-first on a same-address collision.
        drive(1'b0, 1'b1, 7, 8'h5C, 7, 1'b1, 1'b0);
        cycle();
        checkVal("wfirst_a", oDataOuta, 8'h5C);
        drive(1'b0, 1'b0, 0, 0, 7, 1'b0, 1'b1);
        cycle();
        checkVal("wfirst_after", oDataOutb, 8'h5C);

        // Different-address collision returns the old word.
        drive(1'b0, 1'b1, 0, 8'hFF, 1023, 1'b0, 1'b1);
        cycle();
        checkVal("diff_b", oDataOutb, 8'hFF);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        cycle();
        checkVal("diff_wr0", oDataOuta, 8'hFF);

        // Reset for one cycle in the middle of back-to-back reads.
        drive(1'b0, 1'b0, 0, 0, 100, 1'b1, 1'b1);
        cycle();
        checkVal("mid_pre_a", oDataOuta, 8'h64);
        drive(1'b1, 1'b0, 0, 0, 101, 1'b1, 1'b1);
        cycle();
        checkVal("mid_rst_a", oDataOuta, 8'h00);
        checkVal("mid_rst_b", oDataOutb, 8'h00);
        drive(1'b0, 1'b0, 0, 0, 102, 1'b1, 1'b1);
        cycle();
        checkVal("mid_post_a", oDataOuta, 8'h66);
        checkVal("mid_post_b", oDataOutb, 8'h66);

        // Randomized traffic; half the reads target the write address.
        for (int n = 0; n < 600; n++) begin
            wa = int'($urandom_range(DEPTH - 1, 0));
            drive(($urandom_range(39, 0) == 0),
                  $urandom_range(1, 0) == 1,
                  wa,
                  int'($urandom_range(255, 0)),
                  ($urandom_range(1, 0) == 1) ? wa : int'($urandom_range(DEPTH - 1, 0)),
                  $urandom_range(1, 0) == 1,
                  $urandom_range(1, 0) == 1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
